xfer_arbiter_ctrl: RTL and testbench
====================================

// Module: xfer_arbiter_ctrl
// PURPOSE
//  Sequences secure memory<->register-file transfers and arbitrates between two requesters (0: core, 1: host).
//  Each accepted request is one transfer: a read from the source array, a key check, then a write to the destination array.
//  Sits between the requesters and the memory/register/security datapath.
//  Drives the memory reg-side addresses and the register-file mem-side addresses.
//  Compares the two 16-bit access keys before any write is allowed.
// PARAMETERS
//  ADDR_W  10  width of memory and register addresses
//  KEY_W   16  width of the access keys
//  LAT     1   source-read latency in cycles, legal range 1..7
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  reqN_valid     in   1       N=0,1: request present
//  reqN_ready     out  1       N=0,1: request accepted this cycle (combinational)
//  reqN_op        in   1       N=0,1: 0=LOAD (mem->reg), 1=STORE (reg->mem)
//  reqN_mem_addr  in   ADDR_W  N=0,1: memory address
//  reqN_reg_addr  in   ADDR_W  N=0,1: register address
//  rsp_valid      out  1       completion present
//  rsp_ready      in   1       consumer takes the completion
//  rsp_id         out  1       requester index of the completion
//  rsp_err        out  1       1 = key mismatch, no write performed
//  key_access_mem in   KEY_W   key from the memory array
//  key_access_reg in   KEY_W   key from the register file
//  mem_rd_addr    out  ADDR_W  memory read address (LOAD source)
//  mem_wr_addr    out  ADDR_W  memory write address (STORE destination)
//  mem_wr_en      out  1       memory write strobe
//  reg_rd_addr    out  ADDR_W  register read address (STORE source)
//  reg_wr_addr    out  ADDR_W  register write address (LOAD destination)
//  reg_wr_en      out  1       register write strobe
//  busy           out  1       high whenever state != IDLE
//  deny_count     out  8       saturating count of denied transfers
// BEHAVIOUR
//  Reset: all registered outputs 0, state IDLE, last_grant=1 (req0 wins first), wait counter 0.
//  Reset mid-transfer: abort immediately. No wr_en and no rsp_valid may follow, and the transfer is lost.
//  IDLE: grant is round-robin. With both valid, the requester != last_grant wins; with one valid, that one wins.
//    reqN_ready = (state==IDLE) & grantN. On accept, latch op, both addresses and id, then go to READ.
//  READ (1 cycle): drive the source address (LOAD: mem_rd_addr; STORE: reg_rd_addr). Load counter=LAT, go to WAIT.
//  WAIT: decrement the counter each cycle. Go to CHECK after LAT cycles.
//  CHECK (1 cycle):
//    keys equal -> WRITE.
//    keys differ -> RESP with err=1, and deny_count++ (saturates at 255).
//  WRITE (1 cycle): drive the destination address and pulse exactly one wr_en (LOAD: reg_wr_en; STORE: mem_wr_en).
//  RESP: hold rsp_valid/rsp_id/rsp_err stable until rsp_ready. On the handshake: last_grant=id, go to IDLE.
//  Address hold: all address outputs hold their latched values from READ through RESP. They return to 0 in IDLE.
//  Mutual exclusion: mem_wr_en and reg_wr_en are never high together, and never outside WRITE.
//  Latency (LAT=1, accept in cycle 0): READ c1, WAIT c2, CHECK c3, WRITE c4, rsp_valid from c5.
//    Next accept is no earlier than the cycle after the rsp handshake, so there is one transfer in flight at a time.
//  Requests that arrive while busy are held off: ready stays 0 and the requester keeps valid asserted.
// TESTING
//  1. Single LOAD, req0 mem=0x005 reg=0x003, keys equal, LAT=1:
//     reg_wr_en pulses once in c4 with reg_wr_addr=0x003. rsp id=0 err=0 in c5.
//  2. STORE, req1 reg=0x010 mem=0x3FF, keys 0xA5A5/0xA5A5:
//     reg_rd_addr=0x010 from READ. mem_wr_en pulses once with mem_wr_addr=0x3FF. rsp id=1.
//  3. Key mismatch 0x1234 vs 0x1235 on a LOAD:
//     no wr_en at all. rsp_err=1, deny_count 0->1. Force 256 denials -> deny_count stays 255.
//  4. Both valid continuously for 4 transfers: grants go 0,1,0,1. rsp_ready low for 3 cycles -> rsp_valid/id held, no new accept.
//  5. Assert rst_n=0 during WAIT of a STORE: mem_wr_en never pulses, busy=0, and the next grant goes to req0.
//  6. LAT=7: exactly 7 WAIT cycles. rsp_valid appears 11 cycles after accept.

Source files
------------

// File: rtl/xfer_arbiter_ctrl.sv
// rtl/xfer_arbiter_ctrl.sv - two-requester round-robin arbiter and sequencer for key-checked mem<->reg transfers
//
// Purpose:
//   Accepts one transfer at a time from requester 0 (core) or 1 (host).
//   Each transfer runs READ -> WAIT (LAT cycles) -> CHECK -> WRITE -> RESP.
//   If the keys differ in CHECK, the write is skipped, an error completion is
//   returned, and the saturating deny counter is incremented.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/ready/op/mem_addr/
//     reg_addr (N=0,1)              request channels; ready is combinational
//   rsp_valid/ready/id/err          completion channel, held until rsp_ready
//   key_access_mem/key_access_reg   keys compared in CHECK
//   mem_rd_addr, mem_wr_addr,
//     mem_wr_en                     memory-side address/strobe
//   reg_rd_addr, reg_wr_addr,
//     reg_wr_en                     register-file-side address/strobe
//   busy                            high whenever not IDLE
//   deny_count                      saturating count of key-mismatch denials
module xfer_arbiter_ctrl #(
    parameter int ADDR_W = 10,
    parameter int KEY_W  = 16,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_op,
    input  logic [ADDR_W-1:0] req0_mem_addr,
    input  logic [ADDR_W-1:0] req0_reg_addr,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_op,
    input  logic [ADDR_W-1:0] req1_mem_addr,
    input  logic [ADDR_W-1:0] req1_reg_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_err,
    input  logic [KEY_W-1:0]  key_access_mem,
    input  logic [KEY_W-1:0]  key_access_reg,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] reg_rd_addr,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic              reg_wr_en,
    output logic              busy,
    output logic [7:0]        deny_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WRITE = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [2:0] LAT_CNT = 3'(LAT);

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        deny_q, deny_d;

    logic              grant_any;
    logic              grant_id;

    // Round-robin: on contention the requester that was not served last wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            reg_addr_q   <= '0;
            cnt_q        <= 3'd0;
            deny_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            reg_addr_q   <= reg_addr_d;
            cnt_q        <= cnt_d;
            deny_q       <= deny_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        reg_addr_d   = reg_addr_q;
        cnt_d        = cnt_q;
        deny_d       = deny_q;

        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp_valid    = 1'b0;
        rsp_id       = 1'b0;
        rsp_err      = 1'b0;
        mem_wr_en    = 1'b0;
        reg_wr_en    = 1'b0;
        mem_rd_addr  = '0;
        mem_wr_addr  = '0;
        reg_rd_addr  = '0;
        reg_wr_addr  = '0;
        busy         = (state_q != S_IDLE);

        // Latched addresses are presented for the whole transfer and only on
        // the ports that belong to the direction of the transfer.
        if (state_q != S_IDLE) begin
            if (op_q) begin
                reg_rd_addr = reg_addr_q;
                mem_wr_addr = mem_addr_q;
            end else begin
                mem_rd_addr = mem_addr_q;
                reg_wr_addr = reg_addr_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    id_d       = grant_id;
                    op_d       = grant_id ? req1_op       : req0_op;
                    mem_addr_d = grant_id ? req1_mem_addr : req0_mem_addr;
                    reg_addr_d = grant_id ? req1_reg_addr : req0_reg_addr;
                    err_d      = 1'b0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = LAT_CNT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter enters at LAT, so CHECK follows exactly LAT WAIT cycles.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (key_access_mem == key_access_reg) begin
                    state_d = S_WRITE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                    if (deny_q != 8'hFF) begin
                        deny_d = deny_q + 8'd1;
                    end
                end
            end
            S_WRITE: begin
                mem_wr_en = op_q;
                reg_wr_en = ~op_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_err   = err_q;
                if (rsp_ready) begin
                    last_grant_d = id_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign deny_count = deny_q;

endmodule

// File: tb/tb_xfer_arbiter_ctrl.sv
// tb/tb_xfer_arbiter_ctrl.sv - table-driven bench for xfer_arbiter_ctrl
module tb_xfer_arbiter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_op;
    logic [9:0]  req0_mem_addr, req0_reg_addr;
    logic        req1_valid, req1_ready, req1_op;
    logic [9:0]  req1_mem_addr, req1_reg_addr;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] key_access_mem, key_access_reg;
    logic [9:0]  mem_rd_addr, mem_wr_addr, reg_rd_addr, reg_wr_addr;
    logic        mem_wr_en, reg_wr_en, busy;
    logic [7:0]  deny_count;

    logic        v7_valid, v7_ready, rsp7_ready;
    logic        req1_ready7, rsp_valid7, rsp_id7, rsp_err7;
    logic [9:0]  mem_rd_addr7, mem_wr_addr7, reg_rd_addr7, reg_wr_addr7;
    logic        mem_wr_en7, reg_wr_en7, busy7;
    logic [7:0]  deny7;

    int nvec  = 0;
    int nfail = 0;
    int nboth = 0;

    xfer_arbiter_ctrl #(.ADDR_W(10), .KEY_W(16), .LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_mem_addr(req0_mem_addr), .req0_reg_addr(req0_reg_addr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_mem_addr(req1_mem_addr), .req1_reg_addr(req1_reg_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .key_access_mem(key_access_mem), .key_access_reg(key_access_reg),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en),
        .reg_rd_addr(reg_rd_addr), .reg_wr_addr(reg_wr_addr), .reg_wr_en(reg_wr_en),
        .busy(busy), .deny_count(deny_count)
    );

    xfer_arbiter_ctrl #(.ADDR_W(10), .KEY_W(16), .LAT(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v7_valid), .req0_ready(v7_ready), .req0_op(1'b0),
        .req0_mem_addr(10'h123), .req0_reg_addr(10'h045),
        .req1_valid(1'b0), .req1_ready(req1_ready7), .req1_op(1'b0),
        .req1_mem_addr(10'h000), .req1_reg_addr(10'h000),
        .rsp_valid(rsp_valid7), .rsp_ready(rsp7_ready), .rsp_id(rsp_id7), .rsp_err(rsp_err7),
        .key_access_mem(key_access_mem), .key_access_reg(key_access_reg),
        .mem_rd_addr(mem_rd_addr7), .mem_wr_addr(mem_wr_addr7), .mem_wr_en(mem_wr_en7),
        .reg_rd_addr(reg_rd_addr7), .reg_wr_addr(reg_wr_addr7), .reg_wr_en(reg_wr_en7),
        .busy(busy7), .deny_count(deny7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       which;
        logic       op;
        logic [9:0] ma;
        logic [9:0] ra;
        logic [15:0] km;
        logic [15:0] kr;
        logic       exp_err;
        int         exp_wr_c;
        int         exp_wr_n;
        logic       exp_wkind;
        logic [9:0] exp_waddr;
        logic [9:0] exp_raddr;
        int         exp_rsp_c;
        logic [7:0] exp_deny;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request at a negedge (cycle 0) and observes cycles 1.. until
    // the completion, which is accepted immediately.
    task automatic run_xfer(input logic which, input logic op,
                            input logic [9:0] ma, input logic [9:0] ra,
                            input logic [15:0] km, input logic [15:0] kr,
                            output logic rdy, output int wr_c, output int wr_n,
                            output logic wkind, output logic [9:0] waddr,
                            output logic [9:0] raddr, output int rsp_c,
                            output logic rid, output logic rerr);
        @(negedge clk);
        key_access_mem = km;
        key_access_reg = kr;
        if (which) begin
            req1_valid = 1'b1; req1_op = op; req1_mem_addr = ma; req1_reg_addr = ra;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_mem_addr = ma; req0_reg_addr = ra;
        end
        #1;
        rdy   = which ? req1_ready : req0_ready;
        wr_c  = -1; wr_n = 0; wkind = 1'b0; waddr = '0; raddr = '0;
        rsp_c = -1; rid = 1'b0; rerr = 1'b0;
        for (int c = 1; c <= 40 && rsp_c < 0; c++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            #1;
            if (c == 1) raddr = op ? reg_rd_addr : mem_rd_addr;
            if (mem_wr_en && reg_wr_en) nboth++;
            if (mem_wr_en || reg_wr_en) begin
                wr_n++;
                wr_c  = c;
                wkind = mem_wr_en;
                waddr = mem_wr_en ? mem_wr_addr : reg_wr_addr;
            end
            if (rsp_valid) begin
                rsp_c = c; rid = rsp_id; rerr = rsp_err;
                rsp_ready = 1'b1;
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic       r_rdy, r_wkind, r_id, r_err;
    int         r_wr_c, r_wr_n, r_rsp_c;
    logic [9:0] r_waddr, r_raddr;
    int         g, wr7_c, rsp7_c, n_bad;
    logic [1:0] exp_grant [4];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 10'h005, 10'h003, 16'h1111, 16'h1111, 1'b0, 4, 1, 1'b0, 10'h003, 10'h005, 5, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 10'h3FF, 10'h010, 16'hA5A5, 16'hA5A5, 1'b0, 4, 1, 1'b1, 10'h3FF, 10'h010, 5, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 10'h100, 10'h2AA, 16'h1234, 16'h1235, 1'b1, -1, 0, 1'b0, 10'h000, 10'h100, 4, 8'd1};
        tbl[3] = '{1'b1, 1'b1, 10'h000, 10'h3FF, 16'hFFFF, 16'hFFFF, 1'b0, 4, 1, 1'b1, 10'h000, 10'h3FF, 5, 8'd1};
        tbl[4] = '{1'b0, 1'b1, 10'h155, 10'h0AA, 16'h0000, 16'h8000, 1'b1, -1, 0, 1'b0, 10'h000, 10'h0AA, 4, 8'd2};
        exp_grant[0] = 2'd0; exp_grant[1] = 2'd1; exp_grant[2] = 2'd0; exp_grant[3] = 2'd1;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 1'b0; req0_mem_addr = '0; req0_reg_addr = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_mem_addr = '0; req1_reg_addr = '0;
        rsp_ready = 1'b0; key_access_mem = '0; key_access_reg = '0;
        v7_valid = 1'b0; rsp7_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_deny", {24'd0, deny_count}, 32'd0);
        chk("reset_addrs", {mem_rd_addr, mem_wr_addr, reg_rd_addr}, 32'd0);
        chk("reset_strobes", {30'd0, mem_wr_en, reg_wr_en}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_xfer(tbl[i].which, tbl[i].op, tbl[i].ma, tbl[i].ra, tbl[i].km, tbl[i].kr,
                     r_rdy, r_wr_c, r_wr_n, r_wkind, r_waddr, r_raddr, r_rsp_c, r_id, r_err);
            chk($sformatf("v%0d_ready", i), {31'd0, r_rdy}, 32'd1);
            chk($sformatf("v%0d_wr_count", i), r_wr_n, tbl[i].exp_wr_n);
            chk($sformatf("v%0d_wr_cycle", i), r_wr_c, tbl[i].exp_wr_c);
            chk($sformatf("v%0d_wr_mem_strobe", i), {31'd0, r_wkind}, {31'd0, tbl[i].exp_wkind});
            chk($sformatf("v%0d_wr_addr", i), {22'd0, r_waddr}, {22'd0, tbl[i].exp_waddr});
            chk($sformatf("v%0d_src_addr", i), {22'd0, r_raddr}, {22'd0, tbl[i].exp_raddr});
            chk($sformatf("v%0d_rsp_cycle", i), r_rsp_c, tbl[i].exp_rsp_c);
            chk($sformatf("v%0d_rsp_id", i), {31'd0, r_id}, {31'd0, tbl[i].which});
            chk($sformatf("v%0d_rsp_err", i), {31'd0, r_err}, {31'd0, tbl[i].exp_err});
            #1;
            chk($sformatf("v%0d_deny", i), {24'd0, deny_count}, {24'd0, tbl[i].exp_deny});
            chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_idle_addrs", i), {2'd0, mem_wr_addr, reg_wr_addr, reg_rd_addr}, 32'd0);
        end

        // 256 further denials: counter must pin at 255.
        for (int i = 0; i < 256; i++) begin
            run_xfer(1'b0, 1'b0, 10'h001, 10'h002, 16'h1234, 16'h1235,
                     r_rdy, r_wr_c, r_wr_n, r_wkind, r_waddr, r_raddr, r_rsp_c, r_id, r_err);
            if (r_wr_n != 0) n_bad++;
        end
        #1;
        chk("deny_saturated", {24'd0, deny_count}, 32'd255);
        chk("deny_no_writes", n_bad, 32'd0);
        chk("mutual_exclusion", nboth, 32'd0);

        // Reset during WAIT of a STORE.
        @(negedge clk);
        key_access_mem = 16'h7777; key_access_reg = 16'h7777;
        req1_valid = 1'b1; req1_op = 1'b1; req1_mem_addr = 10'h222; req1_reg_addr = 10'h011;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_abort_busy", {31'd0, busy}, 32'd0);
        chk("reset_abort_deny", {24'd0, deny_count}, 32'd0);
        n_bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            #1;
            if (mem_wr_en || reg_wr_en || rsp_valid || busy) n_bad++;
        end
        chk("reset_abort_quiet", n_bad, 32'd0);

        // Continuous contention, first grant after reset goes to req0.
        key_access_mem = 16'h5A5A; key_access_reg = 16'h5A5A;
        req0_valid = 1'b1; req0_op = 1'b0; req0_mem_addr = 10'h0C0; req0_reg_addr = 10'h00C;
        req1_valid = 1'b1; req1_op = 1'b0; req1_mem_addr = 10'h0D0; req1_reg_addr = 10'h00D;
        for (int t = 0; t < 4; t++) begin
            g = -1;
            for (int w = 0; w < 10; w++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    g = req1_ready ? 1 : 0;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("rr_grant%0d", t), g, {30'd0, exp_grant[t]});
            r_rsp_c = -1;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                #1;
                if (rsp_valid) begin
                    r_rsp_c = w;
                    break;
                end
            end
            chk($sformatf("rr_rsp_seen%0d", t), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("rr_rsp_id%0d", t), {31'd0, rsp_id}, {30'd0, exp_grant[t]});
            if (t == 0) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    #1;
                    chk($sformatf("stall_valid%0d", s), {31'd0, rsp_valid}, 32'd1);
                    chk($sformatf("stall_id%0d", s), {31'd0, rsp_id}, 32'd0);
                    chk($sformatf("stall_no_accept%0d", s), {30'd0, req0_ready, req1_ready}, 32'd0);
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // LAT=7 instance: WRITE at cycle 10, completion at cycle 11 after accept.
        @(negedge clk);
        key_access_mem = 16'h3C3C; key_access_reg = 16'h3C3C;
        v7_valid = 1'b1;
        #1;
        chk("lat7_ready", {31'd0, v7_ready}, 32'd1);
        wr7_c = -1; rsp7_c = -1;
        for (int c = 1; c <= 20 && rsp7_c < 0; c++) begin
            @(negedge clk);
            v7_valid = 1'b0;
            #1;
            if (c == 1) chk("lat7_src_addr", {22'd0, mem_rd_addr7}, 32'h123);
            if (reg_wr_en7) begin
                wr7_c = c;
                chk("lat7_wr_addr", {22'd0, reg_wr_addr7}, 32'h045);
            end
            if (mem_wr_en7) n_bad++;
            if (rsp_valid7) begin
                rsp7_c = c;
                chk("lat7_rsp", {30'd0, rsp_id7, rsp_err7}, 32'd0);
            end
        end
        chk("lat7_wr_cycle", wr7_c, 32'd10);
        chk("lat7_rsp_cycle", rsp7_c, 32'd11);
        @(negedge clk);
        #1;
        chk("lat7_idle", {busy7, req1_ready7, mem_wr_addr7, reg_rd_addr7, deny7}, 32'd0);
        chk("lat7_no_mem_write", n_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
